// File: rtl/blk_ctrl_pkg.sv
// rtl/blk_ctrl_pkg.sv - shared state types for the block controller and its tile sequencers
package blk_ctrl_pkg;

  // Tile sequencer: walks row / N-tile / K-tile and hands out MAC steps and writebacks
  typedef enum logic [1:0] {
    TS_IDLE  = 2'd0,
    TS_ISSUE = 2'd1,
    TS_WB    = 2'd2,
    TS_DONE  = 2'd3
  } tile_seq_state_t;

  // Top-level block controller that launches the two linear stages around the activation
  typedef enum logic [2:0] {
    BC_IDLE    = 3'd0,
    BC_LINEAR1 = 3'd1,
    BC_ACT     = 3'd2,
    BC_LINEAR2 = 3'd3,
    BC_DONE    = 3'd4
  } blk_ctrl_state_t;

  localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/linear_tile_seq_if.sv
// rtl/linear_tile_seq_if.sv - start/config, MAC-step, writeback and status bundle (LINEAR_TILE_SEQ_PERF_EN adds perf_stall_cnt)
interface linear_tile_seq_if #(
  parameter int ROW_W  = 8,
  parameter int TILE_W = 6
);

  logic              start;
  logic [ROW_W-1:0]  cfg_rows;
  logic [TILE_W-1:0] cfg_ntile;
  logic [TILE_W-1:0] cfg_ktile;

  logic              mac_valid;
  logic              mac_ready;
  logic [ROW_W-1:0]  mac_row;
  logic [TILE_W-1:0] mac_ntile;
  logic [TILE_W-1:0] mac_ktile;
  logic              mac_first;
  logic              mac_last;

  logic              wb_valid;
  logic              wb_ready;

  logic              done;
  logic              busy;
  logic              start_err;

`ifdef LINEAR_TILE_SEQ_PERF_EN
  logic [31:0]       perf_stall_cnt;

  // Controller / datapath side
  modport master (
    output start, cfg_rows, cfg_ntile, cfg_ktile, mac_ready, wb_ready,
    input  mac_valid, mac_row, mac_ntile, mac_ktile, mac_first, mac_last,
    input  wb_valid, done, busy, start_err, perf_stall_cnt
  );

  // Sequencer side
  modport slave (
    input  start, cfg_rows, cfg_ntile, cfg_ktile, mac_ready, wb_ready,
    output mac_valid, mac_row, mac_ntile, mac_ktile, mac_first, mac_last,
    output wb_valid, done, busy, start_err, perf_stall_cnt
  );
`else
  // Controller / datapath side
  modport master (
    output start, cfg_rows, cfg_ntile, cfg_ktile, mac_ready, wb_ready,
    input  mac_valid, mac_row, mac_ntile, mac_ktile, mac_first, mac_last,
    input  wb_valid, done, busy, start_err
  );

  // Sequencer side
  modport slave (
    input  start, cfg_rows, cfg_ntile, cfg_ktile, mac_ready, wb_ready,
    output mac_valid, mac_row, mac_ntile, mac_ktile, mac_first, mac_last,
    output wb_valid, done, busy, start_err
  );
`endif

endinterface

// File: rtl/tile_idx_cnt.sv
// rtl/tile_idx_cnt.sv - index register with clear/increment and last-index flag against a limit
module tile_idx_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_idx,
  output logic         o_is_last
);

  logic [W-1:0] r_idx;
  logic [W-1:0] w_limit_m1;

  // The limit is a count, so the last legal index is limit-1; the caller never
  // increments past it, which keeps an all-ones limit from wrapping.
  assign w_limit_m1 = i_limit - {{(W-1){1'b0}}, 1'b1};
  assign o_is_last  = (r_idx == w_limit_m1);
  assign o_idx      = r_idx;

  // Clear wins over increment so a wrap and a restart never fight
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_idx <= '0;
    end else if (i_inc) begin
      r_idx <= r_idx + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/linear_tile_seq.sv
// rtl/linear_tile_seq.sv - row/N-tile/K-tile sequencer for one linear stage (LINEAR_TILE_SEQ_PERF_EN adds stall counter)
module linear_tile_seq
  import blk_ctrl_pkg::*;
#(
  parameter int ROW_W  = 8,
  parameter int TILE_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  linear_tile_seq_if.slave bus
);

  tile_seq_state_t   r_state;
  tile_seq_state_t   w_next;

  logic [ROW_W-1:0]  r_rows;
  logic [TILE_W-1:0] r_ntile;
  logic [TILE_W-1:0] r_ktile;

  logic              w_start_acc;
  logic              w_cfg_zero;
  logic              w_mac_valid;
  logic              w_wb_valid;
  logic              w_done;
  logic              w_mac_hs;
  logic              w_wb_hs;

  logic [ROW_W-1:0]  w_row_idx;
  logic [TILE_W-1:0] w_n_idx;
  logic [TILE_W-1:0] w_k_idx;
  logic              w_r_last;
  logic              w_n_last;
  logic              w_k_last;

  logic              w_r_clr, w_r_inc;
  logic              w_n_clr, w_n_inc;
  logic              w_k_clr, w_k_inc;
  logic              w_coord_live;

  assign w_start_acc = bus.start && (r_state == TS_IDLE);
  assign w_cfg_zero  = (bus.cfg_rows == '0) || (bus.cfg_ntile == '0) || (bus.cfg_ktile == '0);
  assign w_mac_hs    = w_mac_valid && bus.mac_ready;
  assign w_wb_hs     = w_wb_valid && bus.wb_ready;

  // K steps every MAC handshake and restarts on each writeback; N wraps into the next row
  assign w_k_clr = w_start_acc || w_wb_hs;
  assign w_k_inc = w_mac_hs && !w_k_last;
  assign w_n_clr = w_start_acc || (w_wb_hs && w_n_last);
  assign w_n_inc = w_wb_hs && !w_n_last;
  assign w_r_clr = w_start_acc;
  assign w_r_inc = w_wb_hs && w_n_last && !w_r_last;

  tile_idx_cnt #(.W(ROW_W)) u_row_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_r_clr),
    .i_inc     (w_r_inc),
    .i_limit   (r_rows),
    .o_idx     (w_row_idx),
    .o_is_last (w_r_last)
  );

  tile_idx_cnt #(.W(TILE_W)) u_ntile_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_n_clr),
    .i_inc     (w_n_inc),
    .i_limit   (r_ntile),
    .o_idx     (w_n_idx),
    .o_is_last (w_n_last)
  );

  tile_idx_cnt #(.W(TILE_W)) u_ktile_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_k_clr),
    .i_inc     (w_k_inc),
    .i_limit   (r_ktile),
    .o_idx     (w_k_idx),
    .o_is_last (w_k_last)
  );

  // Capture the job shape only when a start is actually accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rows  <= '0;
      r_ntile <= '0;
      r_ktile <= '0;
    end else if (w_start_acc) begin
      r_rows  <= bus.cfg_rows;
      r_ntile <= bus.cfg_ntile;
      r_ktile <= bus.cfg_ktile;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= TS_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next      = r_state;
    w_mac_valid = 1'b0;
    w_wb_valid  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      TS_IDLE: begin
        if (bus.start) begin
          w_next = w_cfg_zero ? TS_DONE : TS_ISSUE;
        end
      end
      TS_ISSUE: begin
        w_mac_valid = 1'b1;
        if (bus.mac_ready && w_k_last) begin
          w_next = TS_WB;
        end
      end
      TS_WB: begin
        w_wb_valid = 1'b1;
        if (bus.wb_ready) begin
          w_next = (w_n_last && w_r_last) ? TS_DONE : TS_ISSUE;
        end
      end
      TS_DONE: begin
        w_done = 1'b1;
        w_next = TS_IDLE;
      end
      default: begin
        w_next = TS_IDLE;
      end
    endcase
  end

  // first/last only mean something while coordinates are being presented
  assign w_coord_live  = (r_state == TS_ISSUE) || (r_state == TS_WB);

  assign bus.mac_valid = w_mac_valid;
  assign bus.wb_valid  = w_wb_valid;
  assign bus.done      = w_done;
  assign bus.busy      = (r_state != TS_IDLE);
  assign bus.start_err = bus.start && (r_state != TS_IDLE) && !rst;
  assign bus.mac_row   = w_row_idx;
  assign bus.mac_ntile = w_n_idx;
  assign bus.mac_ktile = w_k_idx;
  assign bus.mac_first = w_coord_live && (w_k_idx == '0);
  assign bus.mac_last  = w_coord_live && w_k_last;

`ifdef LINEAR_TILE_SEQ_PERF_EN
  logic [PERF_CNT_W-1:0] r_stall_cnt;
  logic                  w_stall;

  assign w_stall = (w_mac_valid && !bus.mac_ready) || (w_wb_valid && !bus.wb_ready);

  // Saturating backpressure counter; holds its value after done until the next job
  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_linear_tile_seq.sv
// tb/tb_linear_tile_seq.sv - scoreboard bench for linear_tile_seq
module tb_linear_tile_seq;

  localparam int RW = 8;
  localparam int TW = 6;

  typedef struct packed {
    logic [RW-1:0] row;
    logic [TW-1:0] nt;
    logic [TW-1:0] kt;
    logic          first;
    logic          last;
  } mac_t;

  typedef struct packed {
    logic [RW-1:0] row;
    logic [TW-1:0] nt;
  } wb_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  logic exp_start_err = 1'b0;

  mac_t mac_q[$];
  wb_t  wb_q[$];
  int   done_q[$];

  linear_tile_seq_if #(.ROW_W(RW), .TILE_W(TW)) bus ();

  linear_tile_seq #(.ROW_W(RW), .TILE_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_job(input int r, input int n, input int k, input int e, input int extra);
    if (r == 0 || n == 0 || k == 0) begin
      done_q.push_back(e);
    end else begin
      for (int ir = 0; ir < r; ir++) begin
        for (int in = 0; in < n; in++) begin
          for (int ik = 0; ik < k; ik++) begin
            mac_q.push_back('{row: RW'(ir), nt: TW'(in), kt: TW'(ik),
                              first: (ik == 0), last: (ik == k - 1)});
          end
          wb_q.push_back('{row: RW'(ir), nt: TW'(in)});
        end
      end
      done_q.push_back(e + r * n * (k + 1) + extra);
    end
  endtask

  task automatic start_job(input int r, input int n, input int k, input int extra);
    bus.cfg_rows  = RW'(r);
    bus.cfg_ntile = TW'(n);
    bus.cfg_ktile = TW'(k);
    bus.start     = 1'b1;
    push_job(r, n, k, cyc + 1, extra);
    wait_cyc(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done_q.size() != 0 && n < budget) begin
      wait_cyc(1);
      n++;
    end
    chk({tag, "_done_left"}, done_q.size(), 0);
    chk({tag, "_mac_left"}, mac_q.size(), 0);
    chk({tag, "_wb_left"}, wb_q.size(), 0);
  endtask

  task automatic check_idle(input string tag, input logic with_coords);
    chk({tag, "_flags"},
        {bus.mac_valid, bus.wb_valid, bus.done, bus.busy, bus.start_err, bus.mac_first, bus.mac_last}, 0);
    if (with_coords) begin
      chk({tag, "_coords"}, {bus.mac_row, bus.mac_ntile, bus.mac_ktile}, 0);
    end
  endtask

  // Monitor: pops and compares whenever the DUT presents an output
  always @(negedge clk) begin
    if (bus.mac_valid) begin
      if (mac_q.size() == 0) begin
        chk("mac_unexpected", bus.mac_valid, 1'b0);
      end else begin
        chk("mac_coord", {bus.mac_row, bus.mac_ntile, bus.mac_ktile, bus.mac_first, bus.mac_last}, mac_q[0]);
        if (bus.mac_ready) void'(mac_q.pop_front());
      end
    end
    if (bus.wb_valid) begin
      if (wb_q.size() == 0) begin
        chk("wb_unexpected", bus.wb_valid, 1'b0);
      end else begin
        chk("wb_coord", {bus.mac_row, bus.mac_ntile}, wb_q[0]);
        if (bus.wb_ready) void'(wb_q.pop_front());
      end
    end
    if (bus.done) begin
      done_cnt++;
      if (done_q.size() == 0) begin
        chk("done_unexpected", bus.done, 1'b0);
      end else begin
        chk("done_cycle", cyc, done_q.pop_front());
      end
    end
    if (bus.start_err || exp_start_err) begin
      chk("start_err", bus.start_err, exp_start_err);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int dc;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.cfg_rows  = '0;
    bus.cfg_ntile = '0;
    bus.cfg_ktile = '0;
    bus.mac_ready = 1'b1;
    bus.wb_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_idle("reset", 1'b1);
`ifdef LINEAR_TILE_SEQ_PERF_EN
    chk("reset_perf", bus.perf_stall_cnt, 0);
`endif
    rst = 1'b0;
    wait_cyc(1);

    // 2x2x3, ready high: 12 MACs, 4 writebacks, done 16 cycles after first issue
    start_job(2, 2, 3, 0);
    chk("first_mac_latency", bus.mac_valid, 1'b1);
    wait_done(60, "basic");

    // Back-to-back start in the cycle after done
    start_job(1, 2, 2, 0);
    chk("b2b_busy", bus.busy, 1'b1);
    wait_done(40, "b2b");

    // MAC backpressure for 5 cycles at the first K step
    bus.mac_ready = 1'b0;
    start_job(1, 1, 2, 5);
    wait_cyc(5);
    bus.mac_ready = 1'b1;
    wait_done(40, "stall");
`ifdef LINEAR_TILE_SEQ_PERF_EN
    chk("stall_perf", bus.perf_stall_cnt, 5);
`endif

    // Zero K count: straight to done, busy for one cycle only
    start_job(2, 2, 0, 0);
    chk("zero_busy", bus.busy, 1'b1);
    chk("zero_valids", {bus.mac_valid, bus.wb_valid}, 0);
    wait_cyc(1);
    chk("zero_idle", bus.busy, 1'b0);
    wait_done(5, "zero");

    // Second start mid-job is ignored and flagged
    dc = done_cnt;
    start_job(1, 2, 2, 0);
    wait_cyc(1);
    bus.cfg_rows  = 8'd5;
    bus.cfg_ntile = 6'd5;
    bus.cfg_ktile = 6'd5;
    bus.start     = 1'b1;
    exp_start_err = 1'b1;
    wait_cyc(1);
    bus.start     = 1'b0;
    exp_start_err = 1'b0;
    wait_done(40, "midstart");
    chk("midstart_single_done", done_cnt - dc, 1);

    // Reset while parked in WB: abort without done
    dc = done_cnt;
    bus.wb_ready = 1'b0;
    start_job(2, 2, 3, 0);
    wait_cyc(4);
    chk("rst_in_wb", bus.wb_valid, 1'b1);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    mac_q.delete();
    wb_q.delete();
    done_q.delete();
    bus.wb_ready = 1'b1;
    check_idle("abort", 1'b1);
`ifdef LINEAR_TILE_SEQ_PERF_EN
    chk("abort_perf", bus.perf_stall_cnt, 0);
`endif
    wait_cyc(2);
    chk("abort_no_done", done_cnt - dc, 0);

    // Fresh job after the abort
    start_job(2, 2, 3, 0);
    wait_done(60, "after_rst");

    // All-ones counts
    start_job(1, 63, 63, 0);
    wait_done(4200, "ones_tile");
    start_job(255, 1, 1, 0);
    wait_done(600, "ones_row");

    check_idle("end", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
